// File: rtl/bit_serial_operand_shifter.sv
// Parallel-to-serial operand feeder for the bit-serial adder: accepts an A/B pair, clears carry, emits LSB first.
// Optional SHIFTER_DOUBLE_BUFFER_EN adds a one-pair holding register so pairs can stream back to back.
module bit_serial_operand_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             a,
    output logic             b,
    output logic             adder_clr,
    output logic             bit_valid,
    output logic             last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sa, sb, sa_n, sb_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             accept;
    logic             at_last;

`ifdef SHIFTER_DOUBLE_BUFFER_EN
    logic [WIDTH-1:0] ha, hb, ha_n, hb_n;
    logic             hold_full, hold_full_n;
`endif

    assign accept  = in_valid & in_ready;
    assign at_last = (state == SHIFT) && (cnt == CNT_LAST);

    always_comb begin
        state_n = state;
        sa_n    = sa;
        sb_n    = sb;
        cnt_n   = cnt;
`ifdef SHIFTER_DOUBLE_BUFFER_EN
        ha_n        = ha;
        hb_n        = hb;
        hold_full_n = hold_full;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = CLEAR;
                    sa_n    = a_in;
                    sb_n    = b_in;
                    cnt_n   = '0;
                end
            end
            CLEAR: state_n = SHIFT;
            SHIFT: begin
                sa_n  = {1'b0, sa[WIDTH-1:1]};
                sb_n  = {1'b0, sb[WIDTH-1:1]};
                cnt_n = cnt + 1'b1;
                if (at_last) begin
`ifdef SHIFTER_DOUBLE_BUFFER_EN
                    if (hold_full) begin
                        state_n     = CLEAR;
                        sa_n        = ha;
                        sb_n        = hb;
                        cnt_n       = '0;
                        hold_full_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
`else
                    state_n = IDLE;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
`ifdef SHIFTER_DOUBLE_BUFFER_EN
        // Placed after the move so a same-edge accept keeps hold_full set.
        if (accept && (state != IDLE)) begin
            ha_n        = a_in;
            hb_n        = b_in;
            hold_full_n = 1'b1;
        end
`endif
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            adder_clr <= 1'b1;
            bit_valid <= 1'b0;
            a         <= 1'b0;
            b         <= 1'b0;
            last      <= 1'b0;
`ifdef SHIFTER_DOUBLE_BUFFER_EN
            ha        <= '0;
            hb        <= '0;
            hold_full <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            sa        <= sa_n;
            sb        <= sb_n;
            cnt       <= cnt_n;
            adder_clr <= (state_n != SHIFT);
            bit_valid <= (state_n == SHIFT);
            a         <= (state_n == SHIFT) & sa_n[0];
            b         <= (state_n == SHIFT) & sb_n[0];
            last      <= (state_n == SHIFT) && (cnt_n == CNT_LAST);
`ifdef SHIFTER_DOUBLE_BUFFER_EN
            ha        <= ha_n;
            hb        <= hb_n;
            hold_full <= hold_full_n;
            in_ready  <= !hold_full_n;
`else
            in_ready  <= (state_n == IDLE);
`endif
        end
    end

endmodule

// File: tb/tb_bit_serial_operand_shifter.sv
// Directed bench for bit_serial_operand_shifter (WIDTH=8 and WIDTH=4 instances).
// Follows SHIFTER_DOUBLE_BUFFER_EN so the same file covers both builds.
module tb_bit_serial_operand_shifter;

`ifdef SHIFTER_DOUBLE_BUFFER_EN
    localparam logic DB = 1'b1;
`else
    localparam logic DB = 1'b0;
`endif
    localparam logic [5:0] IDLE_O = 6'b110000;

    logic       clk;
    logic       reset;
    logic       in_valid, in_ready, a, b, adder_clr, bit_valid, last;
    logic [7:0] a_in, b_in;
    logic       v4, r4, a4, b4, clr4, bv4, last4;
    logic [3:0] a_in4, b_in4;

    int unsigned nvec;
    int unsigned nerr;
    int unsigned cyc;
    int unsigned acc_cyc;

    typedef struct {
        string      name;
        logic [7:0] ai;
        logic [7:0] bi;
        logic [7:0] seqa;
        logic [7:0] seqb;
    } vec_t;
    vec_t tbl [6];

    bit_serial_operand_shifter #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .a(a), .b(b), .adder_clr(adder_clr),
        .bit_valid(bit_valid), .last(last)
    );

    bit_serial_operand_shifter #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(v4), .in_ready(r4),
        .a_in(a_in4), .b_in(b_in4), .a(a4), .b(b4), .adder_clr(clr4),
        .bit_valid(bv4), .last(last4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic chk(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = {in_ready, adder_clr, bit_valid, last, a, b};
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: {rdy,clr,bv,last,a,b} got %b want %b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk4(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = {r4, clr4, bv4, last4, a4, b4};
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: {rdy,clr,bv,last,a,b} got %b want %b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chkn(input string name, input int unsigned got, input int unsigned exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    // Starts at the bit-0 cycle; ends in the cycle after the last bit. seq MSB is the first bit out.
    task automatic bits(input string name, input logic [7:0] seqa, input logic [7:0] seqb, input logic rdy);
        for (int i = 0; i < 8; i++) begin
            chk(name, {rdy, 1'b0, 1'b1, (i == 7), seqa[7-i], seqb[7-i]});
            step;
        end
    endtask

    task automatic send(input string name, input logic [7:0] ai, input logic [7:0] bi,
                        input logic [7:0] seqa, input logic [7:0] seqb, input bit hold);
        chk({name, "_idle"}, IDLE_O);
        in_valid = 1'b1;
        a_in = ai;
        b_in = bi;
        step;
        acc_cyc = cyc;
        if (!hold) begin
            in_valid = 1'b0;
            a_in = ~ai;
            b_in = ~bi;
        end
        chk({name, "_clear"}, {DB, 1'b1, 4'b0000});
        step;
        bits({name, "_bits"}, seqa, seqb, DB);
        chk({name, "_ret"}, IDLE_O);
    endtask

    initial begin
        int unsigned c1;
        tbl[0] = '{"v31_14", 8'h31, 8'h14, 8'b10001100, 8'b00101000};
        tbl[1] = '{"vAA_55", 8'hAA, 8'h55, 8'b01010101, 8'b10101010};
        tbl[2] = '{"v00_FF", 8'h00, 8'hFF, 8'b00000000, 8'b11111111};
        tbl[3] = '{"v80_01", 8'h80, 8'h01, 8'b00000001, 8'b10000000};
        tbl[4] = '{"v02_03", 8'h02, 8'h03, 8'b01000000, 8'b11000000};
        tbl[5] = '{"vC5_3A", 8'hC5, 8'h3A, 8'b10100011, 8'b01011100};

        nvec = 0; nerr = 0; cyc = 0; acc_cyc = 0;
        reset = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
        v4 = 1'b0; a_in4 = '0; b_in4 = '0;
        #1 reset = 1'b1;
        #1 chk("reset_values", IDLE_O);
        chk4("reset_values4", IDLE_O);
        step;
        step;
        reset = 1'b0;
        step;

        for (int v = 0; v < 6; v++)
            send(tbl[v].name, tbl[v].ai, tbl[v].bi, tbl[v].seqa, tbl[v].seqb, 1'b0);

        // Reset lands during bit 3 of 0xFF/0x01, between clock edges.
        chk("rst_idle", IDLE_O);
        in_valid = 1'b1; a_in = 8'hFF; b_in = 8'h01;
        step;
        in_valid = 1'b0;
        chk("rst_clear", {DB, 1'b1, 4'b0000});
        step;
        for (int i = 0; i < 3; i++) begin
            chk("rst_pre_bits", {DB, 1'b0, 1'b1, 1'b0, 1'b1, (i == 0)});
            step;
        end
        chk("rst_bit3", {DB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        #2 reset = 1'b1;
        #1 chk("rst_async", IDLE_O);
        step;
        chk("rst_held", IDLE_O);
        reset = 1'b0;
        step;
        send("after_rst", tbl[4].ai, tbl[4].bi, tbl[4].seqa, tbl[4].seqb, 1'b0);

        // WIDTH=4, 0xF/0xF.
        chk4("w4_idle", IDLE_O);
        v4 = 1'b1; a_in4 = 4'hF; b_in4 = 4'hF;
        step;
        v4 = 1'b0; a_in4 = 4'h0; b_in4 = 4'h0;
        chk4("w4_clear", {DB, 1'b1, 4'b0000});
        step;
        for (int i = 0; i < 4; i++) begin
            chk4("w4_bits", {DB, 1'b0, 1'b1, (i == 3), 1'b1, 1'b1});
            step;
        end
        chk4("w4_ret", IDLE_O);

`ifndef SHIFTER_DOUBLE_BUFFER_EN
        // in_valid held across the whole transfer; second accept WIDTH+2 cycles later.
        send("held1", 8'hAA, 8'h55, 8'b01010101, 8'b10101010, 1'b1);
        c1 = acc_cyc;
        send("held2", 8'hAA, 8'h55, 8'b01010101, 8'b10101010, 1'b1);
        in_valid = 1'b0;
        chkn("held_spacing", acc_cyc - c1, 10);
        step;
        chk("held_done", IDLE_O);
`else
        // Three back-to-back pairs through the holding register.
        chk("db_idle", IDLE_O);
        in_valid = 1'b1; a_in = tbl[0].ai; b_in = tbl[0].bi;
        step;
        chk("db_clear1", 6'b110000);
        a_in = tbl[1].ai; b_in = tbl[1].bi;
        step;
        c1 = cyc;
        a_in = tbl[5].ai; b_in = tbl[5].bi;
        bits("db_p1", tbl[0].seqa, tbl[0].seqb, 1'b0);
        chk("db_clear2", 6'b110000);
        step;
        chkn("db_spacing", cyc - c1, 9);
        in_valid = 1'b0; a_in = '0; b_in = '0;
        bits("db_p2", tbl[1].seqa, tbl[1].seqb, 1'b0);
        chk("db_clear3", 6'b110000);
        step;
        bits("db_p3", tbl[5].seqa, tbl[5].seqb, 1'b1);
        chk("db_done", IDLE_O);

        // Reset while a pair waits in the holding register.
        in_valid = 1'b1; a_in = tbl[0].ai; b_in = tbl[0].bi;
        step;
        a_in = tbl[1].ai; b_in = tbl[1].bi;
        step;
        in_valid = 1'b0;
        chk("dbr_full", {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        step;
        #2 reset = 1'b1;
        #1 chk("dbr_async", IDLE_O);
        step;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step;
            chk("dbr_quiet", IDLE_O);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
